// File: rtl/qick_vec_pulser.sv
// qick_vec_pulser: queues (mask, delay, length) pulse commands and plays them one at a time on a registered vector.
// Optional QICK_VEC_PULSER_CNT_EN adds done_cnt_o, a wrapping count of completed pulses.
module qick_vec_pulser #(
    parameter int OUT_DW  = 16,
    parameter int LEN_DW  = 16,
    parameter int FIFO_AW = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [OUT_DW-1:0] cmd_mask_i,
    input  logic [LEN_DW-1:0] cmd_dly_i,
    input  logic [LEN_DW-1:0] cmd_len_i,
    input  logic              abort_i,
    output logic [OUT_DW-1:0] dout_o,
    output logic              busy_o,
    output logic [FIFO_AW:0]  fifo_cnt_o,
    output logic              done_o,
    output logic              err_o
`ifdef QICK_VEC_PULSER_CNT_EN
    ,
    output logic [15:0]       done_cnt_o
`endif
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DELAY, PULSE} state_t;

    state_t              state;
    logic [OUT_DW-1:0]   mask_mem [DEPTH];
    logic [LEN_DW-1:0]   dly_mem  [DEPTH];
    logic [LEN_DW-1:0]   len_mem  [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
    logic [OUT_DW-1:0]   mask_r;
    logic [LEN_DW-1:0]   len_r, tcnt;
    logic [OUT_DW-1:0]   head_mask;
    logic [LEN_DW-1:0]   head_dly, head_len;
    logic                push, pop;

    assign cmd_ready_o = (fifo_cnt_o != FULL) && !abort_i;
    assign push        = cmd_valid_i && cmd_ready_o;
    assign pop         = (state == LOAD) && !abort_i;
    assign busy_o      = (state != IDLE) || (fifo_cnt_o != '0);
    assign head_mask   = mask_mem[rd_ptr];
    assign head_dly    = dly_mem[rd_ptr];
    assign head_len    = len_mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mask_mem[wr_ptr] <= cmd_mask_i;
            dly_mem[wr_ptr]  <= cmd_dly_i;
            len_mem[wr_ptr]  <= cmd_len_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            dout_o     <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            mask_r     <= '0;
            len_r      <= '0;
            tcnt       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt_o <= '0;
`ifdef QICK_VEC_PULSER_CNT_EN
            done_cnt_o <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            if (abort_i) begin
                // flush everything; the aborted command never reports done or err
                state      <= IDLE;
                dout_o     <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_cnt_o <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                fifo_cnt_o <= fifo_cnt_o + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
                case (state)
                    IDLE: if (fifo_cnt_o != '0) state <= LOAD;
                    LOAD: begin
                        mask_r <= head_mask;
                        len_r  <= head_len;
                        if (head_len == '0) begin
                            state <= IDLE;
                            err_o <= 1'b1;
                        end else if (head_dly == '0) begin
                            state  <= PULSE;
                            dout_o <= head_mask;
                            tcnt   <= head_len;
                        end else begin
                            state <= DELAY;
                            tcnt  <= head_dly;
                        end
                    end
                    DELAY: begin
                        if (tcnt == LEN_DW'(1)) begin
                            state  <= PULSE;
                            dout_o <= mask_r;
                            tcnt   <= len_r;
                        end else begin
                            tcnt <= tcnt - 1'b1;
                        end
                    end
                    PULSE: begin
                        if (tcnt == LEN_DW'(1)) begin
                            state  <= IDLE;
                            dout_o <= '0;
                            done_o <= 1'b1;
`ifdef QICK_VEC_PULSER_CNT_EN
                            done_cnt_o <= done_cnt_o + 16'd1;
`endif
                        end else begin
                            tcnt <= tcnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qick_vec_pulser.sv
// tb_qick_vec_pulser: directed checks of timing, queueing, len=0 discard, abort and async reset.
module tb_qick_vec_pulser;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        ready;
    logic [15:0] mask = '0;
    logic [15:0] dly = '0;
    logic [15:0] len = '0;
    logic        abort = 1'b0;
    logic [15:0] dout;
    logic        busy;
    logic [3:0]  fcnt;
    logic        done;
    logic        err;
`ifdef QICK_VEC_PULSER_CNT_EN
    logic [15:0] done_cnt;
`endif
    int total = 0;
    int bad = 0;

    qick_vec_pulser dut (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(valid), .cmd_ready_o(ready),
        .cmd_mask_i(mask), .cmd_dly_i(dly), .cmd_len_i(len), .abort_i(abort),
        .dout_o(dout), .busy_o(busy), .fifo_cnt_o(fcnt), .done_o(done), .err_o(err)
`ifdef QICK_VEC_PULSER_CNT_EN
        , .done_cnt_o(done_cnt)
`endif
    );

    always #5 clk = ~clk;

    // pulse log built from the observed vector: mask, length and preceding zero run
    logic [15:0] pm[$];
    int          pl[$];
    int          pg[$];
    int          cur = 0;
    int          zr = 0;
    int          done_n = 0;
    int          err_n = 0;
    always @(negedge clk) begin
        if (dout != 0) begin
            if (cur == 0) begin
                pm.push_back(dout);
                pg.push_back(zr);
            end
            cur++;
            zr = 0;
        end else begin
            if (cur != 0) pl.push_back(cur);
            cur = 0;
            zr++;
        end
        done_n += int'(done);
        err_n  += int'(err);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push1(input logic [15:0] m, input logic [15:0] d, input logic [15:0] l);
        valid = 1'b1;
        mask = m;
        dly = d;
        len = l;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
        cyc(2);
    endtask

    initial begin
        int b, dn, en;
        #12;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_fcnt", 32'(fcnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_ready", 32'(ready), 32'd1);
        @(negedge clk);

        // 1: dly=0 len=3, pulse after E2 for 3 cycles
        dn = done_n;
        push1(16'h0005, 16'd0, 16'd3);
        check("t1_fcnt", 32'(fcnt), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        cyc(1);
        check("t1_load", 32'(dout), 32'd0);
        cyc(1);
        check("t1_p0", 32'(dout), 32'h5);
        check("t1_popped", 32'(fcnt), 32'd0);
        cyc(2);
        check("t1_p2", 32'(dout), 32'h5);
        check("t1_nodone", 32'(done), 32'd0);
        cyc(1);
        check("t1_end", 32'(dout), 32'd0);
        check("t1_done", 32'(done), 32'd1);
        cyc(1);
        check("t1_done_off", 32'(done), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_len", 32'(pl[pl.size()-1]), 32'd3);

        // 2: dly=4 len=1
        cyc(3);
        push1(16'h8000, 16'd4, 16'd1);
        cyc(2);
        check("t2_d0", 32'(dout), 32'd0);
        cyc(3);
        check("t2_d3", 32'(dout), 32'd0);
        cyc(1);
        check("t2_p", 32'(dout), 32'h8000);
        cyc(1);
        check("t2_end", 32'(dout), 32'd0);
        check("t2_done", 32'(done), 32'd1);
        cyc(3);
        check("t2_done_cnt", 32'(done_n - dn), 32'd2);

        // 3: nine back-to-back pushes while a long first pulse plays
        b = pm.size();
        dn = done_n;
        for (int i = 0; i < 9; i++) begin
            valid = 1'b1;
            mask = 16'(1 << i);
            dly = 16'(i % 2);
            len = (i == 0) ? 16'd20 : 16'(i + 1);
            #1 check($sformatf("t3_rdy%0d", i), 32'(ready), 32'd1);
            @(negedge clk);
        end
        valid = 1'b0;
        check("t3_full", 32'(fcnt), 32'd8);
        check("t3_not_ready", 32'(ready), 32'd0);
        wait_idle(400, "t3_timeout");
        check("t3_npulse", 32'(pm.size() - b), 32'd9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("t3_mask%0d", i), 32'(pm[b+i]), 32'(1 << i));
            check($sformatf("t3_len%0d", i), 32'(pl[b+i]), (i == 0) ? 32'd20 : 32'(i + 1));
            if (i > 0) check($sformatf("t3_gap%0d", i), 32'(pg[b+i] >= 2), 32'd1);
        end
        check("t3_dones", 32'(done_n - dn), 32'd9);

        // 4: len=0 command between two valid ones
        b = pm.size();
        dn = done_n;
        en = err_n;
        push1(16'h00F0, 16'd1, 16'd2);
        push1(16'h0F00, 16'd0, 16'd0);
        push1(16'h000F, 16'd2, 16'd2);
        wait_idle(100, "t4_timeout");
        check("t4_npulse", 32'(pm.size() - b), 32'd2);
        check("t4_m0", 32'(pm[b]), 32'h00F0);
        check("t4_m1", 32'(pm[b+1]), 32'h000F);
        check("t4_l0", 32'(pl[b]), 32'd2);
        check("t4_l1", 32'(pl[b+1]), 32'd2);
        check("t4_err", 32'(err_n - en), 32'd1);
        check("t4_done", 32'(done_n - dn), 32'd2);

        // 5: abort mid-pulse with 3 queued; push in abort cycle dropped
        dn = done_n;
        push1(16'h0003, 16'd0, 16'd10);
        push1(16'h0030, 16'd0, 16'd2);
        push1(16'h0300, 16'd0, 16'd2);
        push1(16'h3000, 16'd0, 16'd2);
        check("t5_q", 32'(fcnt), 32'd3);
        check("t5_pulse", 32'(dout), 32'h3);
        abort = 1'b1;
        valid = 1'b1;
        mask = 16'hFFFF;
        dly = 16'd0;
        len = 16'd1;
        #1 check("t5_ready_low", 32'(ready), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        valid = 1'b0;
        check("t5_dout", 32'(dout), 32'd0);
        check("t5_fcnt", 32'(fcnt), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        cyc(20);
        check("t5_quiet", 32'(dout), 32'd0);
        check("t5_nodone", 32'(done_n - dn), 32'd0);
        check("t5_plen", 32'(pl[pl.size()-1]), 32'd2);
`ifdef QICK_VEC_PULSER_CNT_EN
        check("cnt_total", 32'(done_cnt), 32'(done_n));
`endif

        // 6: async reset mid-DELAY and mid-PULSE
        push1(16'h00AA, 16'd10, 16'd5);
        push1(16'h0001, 16'd0, 16'd1);
        cyc(2);
        check("t6_delay_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1 check("t6_d_busy", 32'(busy), 32'd0);
        check("t6_d_fcnt", 32'(fcnt), 32'd0);
        check("t6_d_dout", 32'(dout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("t6_ready", 32'(ready), 32'd1);
        @(negedge clk);
        push1(16'h0055, 16'd0, 16'd10);
        cyc(3);
        check("t6_pulse", 32'(dout), 32'h55);
        #2 rst = 1'b1;
        #1 check("t6_p_dout", 32'(dout), 32'd0);
        check("t6_p_busy", 32'(busy), 32'd0);
`ifdef QICK_VEC_PULSER_CNT_EN
        check("cnt_rst", 32'(done_cnt), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        cyc(5);
        check("t6_after", 32'(dout), 32'd0);
        check("t6_after_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
